mipi_rx_hs_byte_aligner: RTL and testbench

- Downstream of the MIPI receiver. Consumes the deserialized 8-bit HS word stream (HS_RX_DATA / HS_RXD_VALID) plus HS_EN.
- Hunts for the D-PHY SoT sync byte 0xB8 at any bit offset and locks that offset for the burst.
- Emits byte-aligned payload to the fabric link layer, with SoT/EoT strobes, sync-error flags and a per-burst byte count.

---
 rtl/mipi_rx_hs_byte_aligner.sv | 124 ++++++++++++
 tb/tb_mipi_rx_hs_byte_aligner.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mipi_rx_hs_byte_aligner.sv
// mipi_rx_hs_byte_aligner: locks onto the D-PHY SoT sync byte at any bit offset and emits aligned HS payload bytes
// Define MIPI_RX_SYNC_ERR_TOL_EN to also accept a sync byte with a single bit error (flagged on SOT_ERR_SOFT).
module mipi_rx_hs_byte_aligner #(
  parameter logic [7:0] SYNC_BYTE = 8'hB8,
  parameter int SYNC_TIMEOUT = 16
) (
  input  logic        CLK_IN,
  input  logic        RST,
  input  logic        HS_EN,
  input  logic [7:0]  HS_RX_DATA,
  input  logic        HS_RXD_VALID,
  output logic [7:0]  BYTE_DATA,
  output logic        BYTE_VALID,
  output logic        SOT,
  output logic        EOT,
  output logic        SOT_ERR,
  output logic        SOT_ERR_SOFT,
  output logic [2:0]  ALIGN_OFFSET,
  output logic [15:0] BYTE_CNT
);
  typedef enum logic [1:0] {IDLE, HUNT, LOCKED, ERR} state_t;
  state_t state;
  logic [7:0] prev;
  logic [7:0] tmo_cnt;
  logic [7:0] tmo_nxt;
  logic [15:0] win;
  logic exact_hit;
  logic [2:0] exact_k;
  logic lock_hit;
  logic lock_soft;
  logic [2:0] lock_k;
  assign win = {HS_RX_DATA, prev};
  assign tmo_nxt = tmo_cnt + 8'd1;
  always_comb begin
    exact_hit = 1'b0;
    exact_k = '0;
    for (int i = 7; i >= 0; i--) begin
      if (win[i +: 8] == SYNC_BYTE) begin
        exact_hit = 1'b1;
        exact_k = 3'(i);
      end
    end
  end
`ifdef MIPI_RX_SYNC_ERR_TOL_EN
  logic soft_hit;
  logic [2:0] soft_k;
  always_comb begin
    soft_hit = 1'b0;
    soft_k = '0;
    for (int i = 7; i >= 0; i--) begin
      if ($countones(win[i +: 8] ^ SYNC_BYTE) == 1) begin
        soft_hit = 1'b1;
        soft_k = 3'(i);
      end
    end
  end
  // An exact match at any offset outranks a 1-bit-error match
  assign lock_soft = !exact_hit && soft_hit;
  assign lock_k = exact_hit ? exact_k : soft_k;
`else
  assign lock_soft = 1'b0;
  assign lock_k = exact_k;
`endif
  assign lock_hit = exact_hit || lock_soft;
  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      state <= IDLE;
      prev <= '0;
      tmo_cnt <= '0;
      BYTE_DATA <= '0;
      BYTE_VALID <= 1'b0;
      SOT <= 1'b0;
      EOT <= 1'b0;
      SOT_ERR <= 1'b0;
      SOT_ERR_SOFT <= 1'b0;
      ALIGN_OFFSET <= '0;
      BYTE_CNT <= '0;
    end else begin
      BYTE_VALID <= 1'b0;
      SOT <= 1'b0;
      EOT <= 1'b0;
      SOT_ERR <= 1'b0;
      SOT_ERR_SOFT <= 1'b0;
      if (HS_RXD_VALID) prev <= HS_RX_DATA;
      case (state)
        IDLE: begin
          prev <= '0;
          tmo_cnt <= '0;
          if (HS_EN) state <= HUNT;
        end
        HUNT: begin
          if (!HS_EN) state <= IDLE;
          else if (HS_RXD_VALID) begin
            if (lock_hit) begin
              ALIGN_OFFSET <= lock_k;
              BYTE_CNT <= '0;
              SOT <= 1'b1;
              SOT_ERR_SOFT <= lock_soft;
              state <= LOCKED;
            end else begin
              tmo_cnt <= tmo_nxt;
              if (tmo_nxt == 8'(SYNC_TIMEOUT)) begin
                SOT_ERR <= 1'b1;
                state <= ERR;
              end
            end
          end
        end
        LOCKED: begin
          if (!HS_EN) begin
            EOT <= 1'b1;
            state <= IDLE;
          end else if (HS_RXD_VALID) begin
            BYTE_DATA <= win[ALIGN_OFFSET +: 8];
            BYTE_VALID <= 1'b1;
            BYTE_CNT <= (BYTE_CNT == 16'hFFFF) ? BYTE_CNT : BYTE_CNT + 16'd1;
          end
        end
        ERR: if (!HS_EN) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mipi_rx_hs_byte_aligner.sv
// tb_mipi_rx_hs_byte_aligner: directed checks of sync hunt, aligned output, timeout, gaps, EOT and reset
// Soft-sync expectations follow MIPI_RX_SYNC_ERR_TOL_EN.
module tb_mipi_rx_hs_byte_aligner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hs_en = 1'b0;
  logic [7:0] hs_rx_data = '0;
  logic hs_rxd_valid = 1'b0;
  logic [7:0] byte_data;
  logic byte_valid, sot, eot, sot_err, sot_err_soft;
  logic [2:0] align_offset;
  logic [15:0] byte_cnt;
  logic [31:0] outs;
  int checks = 0;
  int errors = 0;
  logic seen;
  always #5 clk = ~clk;
  assign outs = {byte_data, byte_valid, sot, eot, sot_err, sot_err_soft, align_offset, byte_cnt};
  mipi_rx_hs_byte_aligner #(.SYNC_TIMEOUT(4)) dut (
    .CLK_IN(clk),
    .RST(rst),
    .HS_EN(hs_en),
    .HS_RX_DATA(hs_rx_data),
    .HS_RXD_VALID(hs_rxd_valid),
    .BYTE_DATA(byte_data),
    .BYTE_VALID(byte_valid),
    .SOT(sot),
    .EOT(eot),
    .SOT_ERR(sot_err),
    .SOT_ERR_SOFT(sot_err_soft),
    .ALIGN_OFFSET(align_offset),
    .BYTE_CNT(byte_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic en, input logic v, input logic [7:0] d);
    hs_en = en;
    hs_rxd_valid = v;
    hs_rx_data = d;
    @(posedge clk);
    #1;
  endtask
  initial begin
    cyc(0, 0, 8'h00);
    cyc(0, 0, 8'h00);
    check("reset_outs", outs, 32'h0);
    rst = 1'b0;
    cyc(0, 0, 8'h00);
    check("idle_outs", outs, 32'h0);
    // aligned: sync byte sits in prev when 11 arrives, so lock lands at offset 0 on that sample
    cyc(1, 0, 8'h00);
    cyc(1, 1, 8'h00);
    check("al_nosot0", sot, 0);
    cyc(1, 1, 8'hB8);
    check("al_nosot1", sot, 0);
    cyc(1, 1, 8'h11);
    check("al_sot", sot, 1);
    check("al_off", align_offset, 0);
    check("al_bv_on_sot", byte_valid, 0);
    check("al_soft", sot_err_soft, 0);
    cyc(1, 1, 8'h22);
    check("al_b0", {byte_valid, byte_data}, 9'h111);
    check("al_cnt1", byte_cnt, 1);
    cyc(1, 1, 8'h33);
    check("al_b1", {byte_valid, byte_data}, 9'h122);
    check("al_cnt2", byte_cnt, 2);
    cyc(0, 0, 8'h00);
    check("al_eot", {eot, byte_valid}, 2'b10);
    check("al_cnt_hold", byte_cnt, 2);
    cyc(0, 0, 8'h00);
    check("al_eot_pulse", eot, 0);
    // offset 3
    cyc(1, 0, 8'h00);
    cyc(1, 1, 8'hC0);
    check("o3_nosot", sot, 0);
    cyc(1, 1, 8'h8D);
    check("o3_sot", sot, 1);
    check("o3_off", align_offset, 3);
    check("o3_cnt0", byte_cnt, 0);
    cyc(1, 1, 8'h10);
    check("o3_b0", {byte_valid, byte_data}, 9'h111);
    cyc(1, 1, 8'h01);
    check("o3_b1", {byte_valid, byte_data}, 9'h122);
    cyc(0, 0, 8'h00);
    check("o3_eot", eot, 1);
    check("o3_off_hold", align_offset, 3);
    cyc(0, 0, 8'h00);
    // gaps and HS_EN priority
    cyc(1, 0, 8'h00);
    cyc(1, 1, 8'h00);
    cyc(1, 1, 8'hB8);
    cyc(1, 1, 8'h11);
    check("gp_sot", sot, 1);
    cyc(1, 1, 8'h33);
    check("gp_b0", {byte_valid, byte_data}, 9'h111);
    cyc(1, 0, 8'hAA);
    check("gp_gap", {byte_valid, byte_data}, 9'h011);
    cyc(1, 1, 8'h44);
    check("gp_b1", {byte_valid, byte_data}, 9'h133);
    check("gp_cnt", byte_cnt, 2);
    cyc(0, 1, 8'h55);
    check("gp_eot", {eot, byte_valid}, 2'b10);
    check("gp_cnt_final", byte_cnt, 2);
    check("gp_data_hold", byte_data, 8'h33);
    cyc(0, 0, 8'h00);
    // hunt timeout
    cyc(1, 0, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1, 1, 8'h00);
    check("to_early", sot_err, 0);
    cyc(1, 1, 8'h00);
    check("to_err", {sot_err, sot, byte_valid}, 3'b100);
    seen = 1'b0;
    cyc(1, 1, 8'hB8);
    seen |= sot | sot_err | byte_valid | eot;
    cyc(1, 1, 8'h11);
    seen |= sot | sot_err | byte_valid | eot;
    cyc(1, 1, 8'h22);
    seen |= sot | sot_err | byte_valid | eot;
    check("to_ignored", seen, 0);
    cyc(0, 0, 8'h00);
    check("to_no_eot", eot, 0);
    cyc(0, 0, 8'h00);
    // reset mid-burst, then re-hunt
    cyc(1, 0, 8'h00);
    cyc(1, 1, 8'h00);
    cyc(1, 1, 8'hB8);
    cyc(1, 1, 8'h11);
    cyc(1, 1, 8'h22);
    check("rs_pre_bv", byte_valid, 1);
    rst = 1'b1;
    cyc(1, 1, 8'h33);
    check("rs_outs", outs, 32'h0);
    rst = 1'b0;
    cyc(0, 0, 8'h00);
    check("rs_no_eot", outs, 32'h0);
    cyc(1, 0, 8'h00);
    cyc(1, 1, 8'hC0);
    cyc(1, 1, 8'h8D);
    check("rs_relock", {sot, align_offset}, 4'b1011);
    cyc(1, 1, 8'h10);
    check("rs_b0", {byte_valid, byte_data}, 9'h111);
    cyc(0, 0, 8'h00);
    check("rs_eot", eot, 1);
    cyc(0, 0, 8'h00);
    // soft sync 00, B9: lower window byte B9 is one bit from B8
    cyc(1, 0, 8'h00);
    cyc(1, 1, 8'h00);
    cyc(1, 1, 8'hB9);
    check("sf_nosot", sot, 0);
    cyc(1, 1, 8'h00);
`ifdef MIPI_RX_SYNC_ERR_TOL_EN
    check("sf_sot", {sot, sot_err_soft, align_offset}, 5'b11000);
    cyc(0, 0, 8'h00);
    check("sf_eot", eot, 1);
`else
    check("sf_nolock", {sot, sot_err_soft, sot_err}, 3'b000);
    cyc(1, 1, 8'h00);
    check("sf_timeout", {sot, sot_err_soft, sot_err}, 3'b001);
    cyc(0, 0, 8'h00);
    check("sf_no_eot", eot, 0);
`endif
    cyc(0, 0, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
